// File: rtl/puf_seq_pkg.sv
// Shared types and defaults for the PUF evaluation sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum, default parameter values, default-width counter
// type and a width helper used to size the bit index and phase timer.
package puf_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_COUNT  = 3'd2,
    ST_DECIDE = 3'd3,
    ST_HOLD   = 3'd4
  } state_e;

  localparam int DEF_RESP_BITS     = 8;
  localparam int DEF_CNT_W         = 16;
  localparam int DEF_SETTLE_CYCLES = 16;
  localparam int DEF_WIN_CYCLES    = 1024;
  localparam int DEF_MARGIN        = 4;

  // Edge-counter value at the default width; instances that override
  // CNT_W declare their own width-matched type.
  typedef logic [DEF_CNT_W-1:0] cnt_t;

  // Register width able to index 0..v-1, never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/puf_edge_counter.sv
// Counts rising edges of an asynchronous oscillator into a saturating counter.
// Latency: two sync flops plus one edge-detect flop before an edge is counted.
// Backpressure: none; counts only while en_i, clr_i has priority.
//
// Ports: clk, rst (async active-high), ro_i (raw oscillator), clr_i (zero the
// count), en_i (count window open), cnt_o (current count, saturates at all-ones).
module puf_edge_counter
  import puf_seq_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ro_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  // [0],[1]: synchronizer; [2]: previous synchronized value for edge detect
  logic [2:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise;

  assign rise = sync_q[1] & ~sync_q[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[1:0], ro_i};
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && rise && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/puf_eval_sequencer.sv
// Sequences a ring-oscillator PUF: per bit settle, count both oscillators, decide.
// Latency: resp_valid rises RESP_BITS*(SETTLE_CYCLES+WIN_CYCLES+1) edges after the start edge.
// Backpressure: response held in HOLD until resp_ready; start ignored while busy.
//
// Ports: clk, rst (async active-high), start/challenge (request), busy, ro_en/ro_sel
// (PUF array control), ro_a/ro_b (raw oscillators), resp/resp_valid/resp_ready
// (response handshake), unstable (per-bit low-margin flags).
// Optional: define PUF_SEQ_MARGIN_EN to compute unstable; otherwise it is tied to 0.
module puf_eval_sequencer
  import puf_seq_pkg::*;
#(
  parameter int RESP_BITS     = DEF_RESP_BITS,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int WIN_CYCLES    = DEF_WIN_CYCLES,
  parameter int MARGIN        = DEF_MARGIN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           challenge,
  output logic                 busy,
  output logic                 ro_en,
  output logic [7:0]           ro_sel,
  input  logic                 ro_a,
  input  logic                 ro_b,
  output logic [RESP_BITS-1:0] resp,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [RESP_BITS-1:0] unstable
);

  localparam int BIT_W   = clog2_min1(RESP_BITS);
  localparam int TMR_MAX = (SETTLE_CYCLES > WIN_CYCLES) ? SETTLE_CYCLES : WIN_CYCLES;
  localparam int TMR_W   = clog2_min1(TMR_MAX);

  typedef logic [CNT_W-1:0] cnt_w_t;

  state_e               state_q, state_d;
  logic [7:0]           chal_q, chal_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [RESP_BITS-1:0] resp_q, resp_d;
  cnt_w_t               cnt_a, cnt_b;
  logic                 settle_done, win_done, last_bit;
  logic                 cnt_clr, cnt_en;

  assign settle_done = (tmr_q == TMR_W'(SETTLE_CYCLES - 1));
  assign win_done    = (tmr_q == TMR_W'(WIN_CYCLES - 1));
  assign last_bit    = (bit_q == BIT_W'(RESP_BITS - 1));

  // Counters are zeroed for the whole settle phase so each bit starts clean.
  assign cnt_clr = (state_q == ST_SETTLE);
  assign cnt_en  = (state_q == ST_COUNT);

  puf_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk   (clk),
    .rst   (rst),
    .ro_i  (ro_a),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .cnt_o (cnt_a)
  );

  puf_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk   (clk),
    .rst   (rst),
    .ro_i  (ro_b),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .cnt_o (cnt_b)
  );

  // State register (plus datapath registers)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      chal_q  <= '0;
      bit_q   <= '0;
      tmr_q   <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      chal_q  <= chal_d;
      bit_q   <= bit_d;
      tmr_q   <= tmr_d;
      resp_q  <= resp_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_SETTLE;
      ST_SETTLE: if (settle_done) state_d = ST_COUNT;
      ST_COUNT:  if (win_done) state_d = ST_DECIDE;
      ST_DECIDE: state_d = last_bit ? ST_HOLD : ST_SETTLE;
      ST_HOLD:   if (resp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath next values; the phase timer restarts at 0 on every phase change.
  always_comb begin
    chal_d = chal_q;
    bit_d  = bit_q;
    tmr_d  = tmr_q;
    resp_d = resp_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          chal_d = challenge;
          bit_d  = '0;
          tmr_d  = '0;
          resp_d = '0;
        end
      end
      ST_SETTLE: tmr_d = settle_done ? '0 : tmr_q + TMR_W'(1);
      ST_COUNT:  tmr_d = win_done ? '0 : tmr_q + TMR_W'(1);
      ST_DECIDE: begin
        resp_d[bit_q] = (cnt_a > cnt_b);
        if (!last_bit) bit_d = bit_q + BIT_W'(1);
      end
      default: ;
    endcase
  end

  // Output logic
  always_comb begin
    busy       = (state_q != ST_IDLE);
    ro_en      = (state_q == ST_SETTLE) || (state_q == ST_COUNT);
    resp_valid = (state_q == ST_HOLD);
    ro_sel     = chal_q + 8'(bit_q);
    resp       = resp_q;
  end

`ifdef PUF_SEQ_MARGIN_EN
  logic [RESP_BITS-1:0] unst_q, unst_d;
  cnt_w_t               diff;

  always_comb begin
    diff   = (cnt_a > cnt_b) ? (cnt_a - cnt_b) : (cnt_b - cnt_a);
    unst_d = unst_q;
    if ((state_q == ST_IDLE) && start) begin
      unst_d = '0;
    end else if (state_q == ST_DECIDE) begin
      unst_d[bit_q] = (32'(diff) < 32'(MARGIN));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) unst_q <= '0;
    else     unst_q <= unst_d;
  end

  assign unstable = unst_q;
`else
  assign unstable = '0;
`endif

endmodule

// File: tb/tb_puf_eval_sequencer.sv
// Directed bench for puf_eval_sequencer with a schedule-level reference model.
// Main instance: RESP_BITS=4, SETTLE=4, WIN=64, MARGIN=4, CNT_W=8; second instance CNT_W=4.
// Oscillators are free-running bench clocks offset from the clk edges.
module tb_puf_eval_sequencer;

  localparam int RB    = 4;
  localparam int S     = 4;
  localparam int W     = 64;
  localparam int MG    = 4;
  localparam int P     = S + W + 1;
  localparam int TOTAL = RB * P;
  localparam int LAT   = 1 + RB * P;

  logic       clk, rst, start, resp_ready;
  logic [7:0] challenge;
  logic       busy, ro_en, resp_valid, ro_a, ro_b;
  logic [7:0] ro_sel;
  logic [RB-1:0] resp, unstable;

  logic       start2, resp_ready2;
  logic       busy2, ro_en2, resp_valid2;
  logic [7:0] ro_sel2;
  logic [RB-1:0] resp2, unstable2;

  logic osc2, osc4, osc8;
  int   src_a, src_b;

  int total = 0;
  int bad   = 0;

  puf_eval_sequencer #(
    .RESP_BITS(RB), .CNT_W(8), .SETTLE_CYCLES(S), .WIN_CYCLES(W), .MARGIN(MG)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .challenge(challenge),
    .busy(busy), .ro_en(ro_en), .ro_sel(ro_sel), .ro_a(ro_a), .ro_b(ro_b),
    .resp(resp), .resp_valid(resp_valid), .resp_ready(resp_ready), .unstable(unstable)
  );

  puf_eval_sequencer #(
    .RESP_BITS(RB), .CNT_W(4), .SETTLE_CYCLES(S), .WIN_CYCLES(W), .MARGIN(MG)
  ) dut2 (
    .clk(clk), .rst(rst), .start(start2), .challenge(8'h40),
    .busy(busy2), .ro_en(ro_en2), .ro_sel(ro_sel2), .ro_a(osc2), .ro_b(1'b0),
    .resp(resp2), .resp_valid(resp_valid2), .resp_ready(resp_ready2), .unstable(unstable2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Oscillators toggle 2 ns away from the nearest clk edge.
  initial begin osc2 = 1'b0; #3; forever #10 osc2 = ~osc2; end
  initial begin osc4 = 1'b0; #3; forever #20 osc4 = ~osc4; end
  initial begin osc8 = 1'b0; #3; forever #40 osc8 = ~osc8; end

  always_comb begin
    case (src_a)
      2: ro_a = osc2;
      4: ro_a = osc4;
      8: ro_a = osc8;
      default: ro_a = 1'b0;
    endcase
    case (src_b)
      2: ro_b = osc2;
      4: ro_b = osc4;
      8: ro_b = osc8;
      default: ro_b = 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Edges in one window for a period given in clk cycles, saturated to the counter width.
  function automatic int exp_cnt(input int period, input int cw);
    int n;
    int mx;
    if (period == 0) return 0;
    n  = W / period;
    mx = (1 << cw) - 1;
    return (n > mx) ? mx : n;
  endfunction

  function automatic logic [RB-1:0] exp_resp();
    return (exp_cnt(src_a, 8) > exp_cnt(src_b, 8)) ? '1 : '0;
  endfunction

  function automatic logic [RB-1:0] exp_unst();
`ifdef PUF_SEQ_MARGIN_EN
    int d;
    d = exp_cnt(src_a, 8) - exp_cnt(src_b, 8);
    if (d < 0) d = -d;
    return (d < MG) ? '1 : '0;
`else
    return '0;
`endif
  endfunction

  // Reference schedule: m_t = edges since the start-sampling edge.
  logic       m_act, m_hold;
  int         m_t;
  logic [7:0] m_ch;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act  <= 1'b0;
      m_hold <= 1'b0;
      m_t    <= 0;
    end else if (m_hold) begin
      if (resp_ready) m_hold <= 1'b0;
    end else if (m_act) begin
      m_t <= m_t + 1;
      if (m_t + 1 == TOTAL) begin
        m_act  <= 1'b0;
        m_hold <= 1'b1;
      end
    end else if (start) begin
      m_act <= 1'b1;
      m_t   <= 0;
      m_ch  <= challenge;
    end
  end

  // Cycle-by-cycle comparison of the main instance against the model.
  always @(posedge clk) begin
    #2;
    if (rst) begin
      chk("rst_busy", busy, 0);
      chk("rst_ro_en", ro_en, 0);
      chk("rst_ro_sel", ro_sel, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp", resp, 0);
      chk("rst_unstable", unstable, 0);
    end else begin
      chk("busy", busy, m_act || m_hold);
      chk("resp_valid", resp_valid, m_hold);
      if (m_act) begin
        logic [7:0] es;
        es = m_ch + 8'(m_t / P);
        chk("ro_en", ro_en, (m_t % P) < (S + W));
        chk("ro_sel", ro_sel, es);
      end else begin
        chk("ro_en_idle", ro_en, 0);
      end
      if (m_hold) begin
        chk("resp", resp, exp_resp());
        chk("unstable", unstable, exp_unst());
      end
    end
  end

  logic [7:0] sel_q[$];

  // Pulse start, then wait for resp_valid; lat counts the start edge as 1.
  task automatic run_eval(input logic [7:0] ch, output int lat);
    sel_q.delete();
    @(negedge clk);
    challenge = ch;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #2;
      lat++;
      if (ro_en && ((sel_q.size() == 0) || (sel_q[$] != ro_sel))) sel_q.push_back(ro_sel);
      if (resp_valid) break;
    end
    if (!resp_valid) chk("timeout_resp_valid", resp_valid, 1);
  endtask

  task automatic ack();
    @(negedge clk);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("ack_valid_low", resp_valid, 0);
    chk("ack_busy_low", busy, 0);
  endtask

  initial begin
    int lat;
    logic [7:0] seq1[4];
    logic [7:0] seq3[4];
    logic [7:0] last_sel2;
    seq1 = '{8'h10, 8'h11, 8'h12, 8'h13};
    seq3 = '{8'hFE, 8'hFF, 8'h00, 8'h01};

    rst = 1'b1; start = 1'b0; resp_ready = 1'b0; challenge = 8'h00;
    start2 = 1'b0; resp_ready2 = 1'b0; src_a = 0; src_b = 0;
    #27;
    chk("reset_busy", busy, 0);
    chk("reset_resp_valid", resp_valid, 0);
    @(negedge clk);
    rst = 1'b0;

    // Test 1: a faster than b, challenge 0x10
    src_a = 4; src_b = 8;
    run_eval(8'h10, lat);
    chk("t1_latency", lat, 277);
    chk("t1_resp", resp, 4'hF);
    chk("t1_unstable", unstable, 4'h0);
    chk("t1_sel_n", sel_q.size(), 4);
    for (int i = 0; i < 4 && i < sel_q.size(); i++) chk("t1_sel", sel_q[i], seq1[i]);
    ack();

    // Test 2: identical oscillators, resp_ready held high throughout
    src_a = 4; src_b = 4;
    @(negedge clk);
    resp_ready = 1'b1;
    run_eval(8'h20, lat);
    chk("t2_latency", lat, LAT);
    chk("t2_resp", resp, 4'h0);
`ifdef PUF_SEQ_MARGIN_EN
    chk("t2_unstable", unstable, 4'hF);
`else
    chk("t2_unstable", unstable, 4'h0);
`endif
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    chk("t2_back_idle", busy, 0);

    // Test 3: challenge wraps past 0xFF; then stall in HOLD with start pulses
    src_a = 8; src_b = 4;
    run_eval(8'hFE, lat);
    chk("t3_sel_n", sel_q.size(), 4);
    for (int i = 0; i < 4 && i < sel_q.size(); i++) chk("t3_sel", sel_q[i], seq3[i]);
    chk("t3_resp", resp, 4'h0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      start = (i % 10 == 0);
    end
    @(negedge clk);
    start = 1'b0;
    chk("t3_hold_valid", resp_valid, 1);
    chk("t3_hold_resp", resp, 4'h0);
    ack();

    // Test 4: reset during COUNT of bit 2, then a fresh evaluation
    src_a = 4; src_b = 8;
    @(negedge clk);
    challenge = 8'h30;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2 * P + S + 10) @(posedge clk);
    #2;
    chk("t4_in_count_en", ro_en, 1);
    chk("t4_in_count_sel", ro_sel, 8'h32);
    #1;
    rst = 1'b1;
    #1;
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_ro_en", ro_en, 0);
    chk("t4_rst_ro_sel", ro_sel, 0);
    chk("t4_rst_valid", resp_valid, 0);
    chk("t4_rst_resp", resp, 0);
    chk("t4_rst_unstable", unstable, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_eval(8'h30, lat);
    chk("t4_latency", lat, 277);
    chk("t4_resp", resp, 4'hF);
    ack();

    // Test 5: 4-bit counters saturate at 15 on a period-2 oscillator vs constant
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    lat = 1;
    last_sel2 = 8'h00;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #2;
      lat++;
      if (ro_en2) last_sel2 = ro_sel2;
      if (resp_valid2) break;
    end
    chk("t5_valid", resp_valid2, 1);
    chk("t5_latency", lat, 277);
    chk("t5_resp", resp2, 4'hF);
    chk("t5_unstable", unstable2, 4'h0);
    chk("t5_busy", busy2, 1);
    chk("t5_last_sel", last_sel2, 8'h43);
    @(negedge clk);
    resp_ready2 = 1'b1;
    @(negedge clk);
    resp_ready2 = 1'b0;
    chk("t5_idle", busy2, 0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
